// File: rtl/obj_tile_fetcher.sv
`default_nettype none
// obj_tile_fetcher: walks one sprite row, reads OBJ VRAM halfwords, emits per-pixel palette indices.
// Optional OBJ_HFLIP_EN adds an hflip input that mirrors the emitted pixel column.
module obj_tile_fetcher (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [9:0]  objname_i,
  input  logic        palette_mode_i,
  input  logic        oam_mode_i,
  input  logic [6:0]  hsize_i,
  input  logic [5:0]  y_i,
`ifdef OBJ_HFLIP_EN
  input  logic        hflip_i,
`endif
  output logic        vram_req_o,
  output logic [14:0] vram_addr_o,
  input  logic        vram_gnt_i,
  input  logic        vram_rvalid_i,
  input  logic [15:0] vram_rdata_i,
  output logic        pix_valid_o,
  output logic [5:0]  pix_x_o,
  output logic [7:0]  pix_index_o,
  output logic        pix_opaque_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [9:0]  objname_q;
  logic        bpp8_q;
  logic        map1d_q;
  logic [3:0]  wdiv8_q;
  logic [5:0]  y_q;
  logic [6:0]  px_q;
  logic [2:0]  cnt_q;
  logic [15:0] data_q;
  logic        vram_req_q;
  logic [14:0] vram_addr_q;
  logic        pix_valid_q;
  logic [5:0]  pix_x_q;
  logic [7:0]  pix_index_q;
  logic        pix_opaque_q;
  logic        busy_q;
  logic        done_q;

  // Byte address of the halfword holding pixel column px of the current row.
  function automatic logic [14:0] calc_addr(input logic [9:0] name, input logic bpp8,
                                            input logic map1d, input logic [3:0] wdiv8,
                                            input logic [5:0] yy, input logic [5:0] px);
    logic [14:0] lin;
    logic [14:0] tile;
    logic [14:0] off;
    lin = 15'(yy[5:3]) * 15'(wdiv8) + 15'(px[5:3]);
    if (map1d)
      tile = 15'(name) + (bpp8 ? {lin[13:0], 1'b0} : lin);
    else
      tile = 15'(name) + {7'b0, yy[5:3], 5'b0} + (bpp8 ? {11'b0, px[5:3], 1'b0} : {12'b0, px[5:3]});
    off = bpp8 ? ({9'b0, yy[2:0], 3'b0} + {12'b0, px[2:0]})
               : ({10'b0, yy[2:0], 2'b0} + {13'b0, px[2:1]});
    calc_addr = ({tile[9:0], 5'b0} + off) & 15'h7FFE;
  endfunction

  logic [2:0]  npix_d;
  logic [6:0]  px_d;
  logic [6:0]  width_d;
  logic [6:0]  col_d;
  logic [5:0]  pix_x_d;
  logic [15:0] src_d;
  logic [7:0]  idx_d;
  logic [15:0] shifted_d;
  logic        unused_bits;

  assign npix_d    = bpp8_q ? 3'd2 : 3'd4;
  assign px_d      = px_q + {4'b0, npix_d};
  assign width_d   = {wdiv8_q, 3'b0};
  assign col_d     = px_q + {4'b0, cnt_q};
  // The first pixel of a halfword comes straight off the read bus.
  assign src_d     = (state_q == S_WAIT) ? vram_rdata_i : data_q;
  assign idx_d     = bpp8_q ? src_d[7:0] : {4'b0, src_d[3:0]};
  assign shifted_d = bpp8_q ? {8'b0, src_d[15:8]} : {4'b0, src_d[15:4]};
  assign unused_bits = &{1'b0, hsize_i[2:0], col_d[6]};

`ifdef OBJ_HFLIP_EN
  logic hflip_q;
  always_ff @(posedge clock_i) begin
    if (reset_i)
      hflip_q <= 1'b0;
    else if (state_q == S_IDLE && start_i)
      hflip_q <= hflip_i;
  end
  // Mod-64 arithmetic keeps W=64 correct: 0 - 1 - col == 63 - col.
  assign pix_x_d = hflip_q ? (width_d[5:0] - 6'd1 - col_d[5:0]) : col_d[5:0];
`else
  assign pix_x_d = col_d[5:0];
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      objname_q    <= '0;
      bpp8_q       <= 1'b0;
      map1d_q      <= 1'b0;
      wdiv8_q      <= '0;
      y_q          <= '0;
      px_q         <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      vram_req_q   <= 1'b0;
      vram_addr_q  <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q      <= 1'b0;
          pix_valid_q <= 1'b0;
          if (start_i) begin
            objname_q <= objname_i;
            bpp8_q    <= palette_mode_i;
            map1d_q   <= oam_mode_i;
            wdiv8_q   <= hsize_i[6:3];
            y_q       <= y_i;
            px_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (hsize_i[6:3] == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              vram_req_q  <= 1'b1;
              vram_addr_q <= calc_addr(objname_i, palette_mode_i, oam_mode_i,
                                       hsize_i[6:3], y_i, 6'd0);
            end
          end
        end
        S_REQ: begin
          if (vram_gnt_i) begin
            vram_req_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (vram_rvalid_i) begin
            pix_valid_q  <= 1'b1;
            pix_x_q      <= pix_x_d;
            pix_index_q  <= idx_d;
            pix_opaque_q <= (idx_d != 8'd0);
            data_q       <= shifted_d;
            cnt_q        <= 3'd1;
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (cnt_q == npix_d) begin
            pix_valid_q <= 1'b0;
            cnt_q       <= '0;
            if (px_d == width_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              px_q        <= px_d;
              state_q     <= S_REQ;
              vram_req_q  <= 1'b1;
              vram_addr_q <= calc_addr(objname_q, bpp8_q, map1d_q, wdiv8_q, y_q, px_d[5:0]);
            end
          end else begin
            pix_valid_q  <= 1'b1;
            pix_x_q      <= pix_x_d;
            pix_index_q  <= idx_d;
            pix_opaque_q <= (idx_d != 8'd0);
            data_q       <= shifted_d;
            cnt_q        <= cnt_q + 3'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vram_req_o   = vram_req_q;
  assign vram_addr_o  = vram_addr_q;
  assign pix_valid_o  = pix_valid_q;
  assign pix_x_o      = pix_x_q;
  assign pix_index_o  = pix_index_q;
  assign pix_opaque_o = pix_opaque_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire
